// File: rtl/adler32_pkg.sv
// rtl/adler32_pkg.sv - shared types and constants for the adler32 message source
//
// Purpose: FSM state encoding, Adler-32 constants and default sizing
//          parameters used by adler32_msg_source and msg_buffer.
package adler32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam int          ADLER_MOD       = 65521;
  localparam logic [31:0] ADLER_EMPTY     = 32'h0000_0001;
  localparam int          DEFAULT_DEPTH   = 16;
  localparam int          DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/msg_buffer.sv
// rtl/msg_buffer.sv - DEPTH x 8 message store, synchronous write, combinational read
//
// Purpose: holds the message bytes streamed by adler32_msg_source.
// Ports:
//   clock   - rising-edge clock
//   wr_en   - write strobe (already qualified by the caller)
//   wr_addr - write address
//   wr_data - write byte
//   rd_addr - read address
//   rd_data - byte at rd_addr (combinational)
module msg_buffer
  import adler32_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  // Contents are deliberately not reset; the message survives a reset pulse.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adler32_msg_source.sv
// rtl/adler32_msg_source.sv - streams a stored message into adler32 and checks the result
//
// Purpose: on start, send msg_len buffered bytes with gap idle cycles between
//          them, then wait for the checksum and report pass/fail/timeout.
// Ports:
//   clock, rst_n              - clock and asynchronous active-low reset
//   wr_en, wr_addr, wr_data   - buffer write port (ignored while busy)
//   msg_len, gap, expected    - run parameters, sampled on an accepted start
//   start                     - begin a run (ignored while busy)
//   busy                      - run in progress (SEND, GAP, WAIT)
//   data_valid, data, last_data - byte stream to adler32
//   checksum_valid, checksum  - result from adler32
//   done                      - one-cycle pulse at end of run
//   pass, timeout             - result of the last run, held until next start
module adler32_msg_source
  import adler32_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int AW      = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   msg_len,
  input  logic [3:0]    gap,
  input  logic [31:0]   expected,
  input  logic          start,
  output logic          busy,
  output logic          data_valid,
  output logic [7:0]    data,
  output logic          last_data,
  input  logic          checksum_valid,
  input  logic [31:0]   checksum,
  output logic          done,
  output logic          pass,
  output logic          timeout
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_END = TW'(TIMEOUT);

  state_t        state;
  logic [AW:0]   len_q;
  logic [3:0]    gap_q;
  logic [3:0]    gap_cnt;
  logic [31:0]   exp_q;
  logic [AW-1:0] idx;
  logic [TW-1:0] wait_cnt;

  logic          idle_like;
  logic          accept;
  logic          wr_ok;
  logic [AW:0]   len_in;
  logic [AW-1:0] next_idx;
  logic [AW-1:0] rd_addr;
  logic [7:0]    mem_rd;
  logic [7:0]    byte_rd;
  logic          last_next;
  logic [TW-1:0] wait_inc;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign accept    = start && idle_like;
  assign wr_ok     = wr_en && idle_like;
  assign len_in    = (msg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : msg_len;
  assign next_idx  = idx + 1'b1;
  assign last_next = ({1'b0, next_idx} == (len_q - 1'b1));
  assign wait_inc  = wait_cnt + 1'b1;

  // The first byte is registered on the start edge, so the read address
  // points at 0 then and at the following byte otherwise.
  assign rd_addr = accept ? '0 : next_idx;

  // A write landing on the start edge must be what the run sends, so the
  // write data bypasses the array for that one read.
  assign byte_rd = (accept && wr_ok && (wr_addr == '0)) ? wr_data : mem_rd;

  msg_buffer #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buf (
    .clock  (clock),
    .wr_en  (wr_ok),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(mem_rd)
  );

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      exp_q      <= '0;
      idx        <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      data       <= '0;
      last_data  <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done       <= 1'b0;
      data_valid <= 1'b0;
      data       <= '0;
      last_data  <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            len_q    <= len_in;
            gap_q    <= gap;
            exp_q    <= expected;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            idx      <= '0;
            gap_cnt  <= '0;
            wait_cnt <= '0;
            if (len_in == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= (expected == ADLER_EMPTY);
            end else begin
              state      <= ST_SEND;
              busy       <= 1'b1;
              data_valid <= 1'b1;
              data       <= byte_rd;
              last_data  <= (len_in == (AW+1)'(1));
            end
          end
        end

        // In SEND the registered outputs carry the current byte; last_data
        // therefore tells whether this was the final one.
        ST_SEND: begin
          if (last_data) begin
            if (TIMEOUT == 1) begin
              state   <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b1;
              pass    <= 1'b0;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= TW'(1);  // the last_data cycle counts as the first
            end
          end else if (gap_q != '0) begin
            state   <= ST_GAP;
            gap_cnt <= gap_q;
          end else begin
            idx        <= next_idx;
            data_valid <= 1'b1;
            data       <= byte_rd;
            last_data  <= last_next;
          end
        end

        ST_GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == 4'd1) begin
            state      <= ST_SEND;
            idx        <= next_idx;
            data_valid <= 1'b1;
            data       <= byte_rd;
            last_data  <= last_next;
          end
        end

        ST_WAIT: begin
          if (checksum_valid) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (checksum == exp_q);
          end else if (wait_inc == T_END) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
            pass     <= 1'b0;
            wait_cnt <= wait_inc;
          end else begin
            wait_cnt <= wait_inc;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adler32_msg_source.sv
// tb/tb_adler32_msg_source.sv - directed self-checking bench for adler32_msg_source
module tb_adler32_msg_source;

  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 64;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [AW:0]   msg_len = '0;
  logic [3:0]    gap = '0;
  logic [31:0]   expected = '0;
  logic          start = 1'b0;
  logic          busy;
  logic          data_valid;
  logic [7:0]    data;
  logic          last_data;
  logic          checksum_valid = 1'b0;
  logic [31:0]   checksum = '0;
  logic          done;
  logic          pass;
  logic          timeout;

  int tests = 0;
  int fails = 0;

  logic [7:0] hello [5] = '{8'd72, 8'd101, 8'd108, 8'd108, 8'd111};

  adler32_msg_source #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock         (clock),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .msg_len       (msg_len),
    .gap           (gap),
    .expected      (expected),
    .start         (start),
    .busy          (busy),
    .data_valid    (data_valid),
    .data          (data),
    .last_data     (last_data),
    .checksum_valid(checksum_valid),
    .checksum      (checksum),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout)
  );

  always #5 clock = ~clock;

  // Behavioural adler32 receiver: accumulates received bytes and answers
  // three cycles after last_data, unless rx_en is low (never answers).
  bit rx_en = 1'b1;
  int ra = 1, rb = 0, pend = 0;
  always @(posedge clock) begin
    checksum_valid <= 1'b0;
    if (!rst_n) begin
      ra = 1; rb = 0; pend = 0;
    end else begin
      if (pend > 0) begin
        pend = pend - 1;
        if (pend == 0) begin
          if (rx_en) begin
            checksum_valid <= 1'b1;
            checksum       <= {rb[15:0], ra[15:0]};
          end
          ra = 1; rb = 0;
        end
      end
      if (data_valid) begin
        ra = (ra + int'(data)) % 65521;
        rb = (rb + ra) % 65521;
        if (last_data) pend = 3;
      end
    end
  end

  // Results of the most recent run, t counted from the cycle after start.
  int         vt[$];
  logic [7:0] vd[$];
  int         last_cnt, last_t, done_t;
  logic       r_pass, r_timeout;
  bit         gap_dirty;

  task automatic load_hello();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = hello[i];
      @(posedge clock); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic run(input int len, input int g, input logic [31:0] exp, input bit resp,
                     input bit busy_wr);
    vt.delete(); vd.delete();
    last_cnt = 0; last_t = -1; done_t = -1; gap_dirty = 0;
    r_pass = 1'bx; r_timeout = 1'bx;
    rx_en = resp; msg_len = (AW+1)'(len); gap = 4'(g); expected = exp; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int t = 1; t <= 300 && done_t < 0; t++) begin
      if (t > 1) begin @(posedge clock); #1; end
      wr_en = 1'b0;
      if (busy_wr && t == 1) begin wr_en = 1'b1; wr_addr = 4'd4; wr_data = 8'hff; end
      if (data_valid) begin vt.push_back(t); vd.push_back(data); end
      else if (data !== 8'd0) gap_dirty = 1;
      if (last_data) begin last_cnt++; last_t = t; end
      if (done) begin done_t = t; r_pass = pass; r_timeout = timeout; end
    end
    wr_en = 1'b0;
    rx_en = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({busy, data_valid, last_data, done, pass, timeout} !== 6'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 000000",
                        {busy, data_valid, last_data, done, pass, timeout});
    end
    tests++;
    if (data !== 8'd0) begin fails++; $display("FAIL reset_data: got %h want 00", data); end
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_hello_b2b();
    load_hello();
    run(5, 0, 32'h058c01f5, 1, 0);
    tests++;
    if (vt.size() != 5) begin fails++; $display("FAIL b2b_count: got %0d want 5", vt.size()); end
    for (int i = 0; i < 5 && i < vt.size(); i++) begin
      tests++;
      if (vt[i] != i + 1 || vd[i] !== hello[i]) begin
        fails++; $display("FAIL b2b_byte%0d: got t=%0d d=%h want t=%0d d=%h",
                          i, vt[i], vd[i], i + 1, hello[i]);
      end
    end
    tests++;
    if (last_cnt != 1 || last_t != 5) begin
      fails++; $display("FAIL b2b_last: got cnt=%0d t=%0d want cnt=1 t=5", last_cnt, last_t);
    end
    tests++;
    if (done_t < 0 || r_pass !== 1'b1 || r_timeout !== 1'b0) begin
      fails++; $display("FAIL b2b_result: got done_t=%0d pass=%b timeout=%b want done pass=1 timeout=0",
                        done_t, r_pass, r_timeout);
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_gap();
    run(5, 3, 32'h058c01f5, 1, 1);  // write during busy must be ignored
    tests++;
    if (vt.size() != 5) begin fails++; $display("FAIL gap_count: got %0d want 5", vt.size()); end
    for (int i = 0; i < 5 && i < vt.size(); i++) begin
      tests++;
      if (vt[i] != 1 + 4 * i || vd[i] !== hello[i]) begin
        fails++; $display("FAIL gap_byte%0d: got t=%0d d=%h want t=%0d d=%h",
                          i, vt[i], vd[i], 1 + 4 * i, hello[i]);
      end
    end
    tests++;
    if (gap_dirty) begin fails++; $display("FAIL gap_idle_data: got nonzero data want 00"); end
    tests++;
    if (done_t < 0 || r_pass !== 1'b1) begin
      fails++; $display("FAIL gap_pass: got done_t=%0d pass=%b want pass=1", done_t, r_pass);
    end
  endtask

  task automatic test_bad_expected();
    run(5, 0, 32'h058c01f6, 1, 0);
    tests++;
    if (done_t < 0 || r_pass !== 1'b0 || r_timeout !== 1'b0) begin
      fails++; $display("FAIL bad_exp: got done_t=%0d pass=%b timeout=%b want pass=0 timeout=0",
                        done_t, r_pass, r_timeout);
    end
  endtask

  task automatic test_timeout();
    run(5, 0, 32'h058c01f5, 0, 0);
    tests++;
    if (done_t < 0 || done_t - last_t != TIMEOUT) begin
      fails++; $display("FAIL to_latency: got %0d want %0d", done_t - last_t, TIMEOUT);
    end
    tests++;
    if (r_timeout !== 1'b1 || r_pass !== 1'b0) begin
      fails++; $display("FAIL to_flags: got timeout=%b pass=%b want timeout=1 pass=0",
                        r_timeout, r_pass);
    end
  endtask

  task automatic test_empty();
    run(0, 0, 32'h0000_0001, 1, 0);
    tests++;
    if (vt.size() != 0 || done_t != 1 || r_pass !== 1'b1) begin
      fails++; $display("FAIL empty_ok: got bytes=%0d done_t=%0d pass=%b want 0 1 1",
                        vt.size(), done_t, r_pass);
    end
    run(0, 0, 32'h0000_0000, 1, 0);
    tests++;
    if (done_t != 1 || r_pass !== 1'b0 || r_timeout !== 1'b0) begin
      fails++; $display("FAIL empty_bad: got done_t=%0d pass=%b timeout=%b want 1 0 0",
                        done_t, r_pass, r_timeout);
    end
  endtask

  task automatic test_reset_midrun();
    msg_len = 5'd5; gap = 4'd0; expected = 32'h058c01f5; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    tests++;
    if (data_valid !== 1'b1 || data !== hello[2]) begin
      fails++; $display("FAIL mid_pre: got valid=%b d=%h want 1 %h", data_valid, data, hello[2]);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, data_valid, last_data, done, pass, timeout} !== 6'b0 || data !== 8'd0) begin
      fails++; $display("FAIL mid_reset: got flags=%b d=%h want 000000 00",
                        {busy, data_valid, last_data, done, pass, timeout}, data);
    end
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    run(5, 0, 32'h058c01f5, 1, 0);
    tests++;
    if (done_t < 0 || r_pass !== 1'b1 || vt.size() != 5) begin
      fails++; $display("FAIL mid_rerun: got done_t=%0d pass=%b bytes=%0d want pass=1 bytes=5",
                        done_t, r_pass, vt.size());
    end
  endtask

  task automatic test_write_on_start();
    wr_en = 1'b1; wr_addr = '0; wr_data = 8'h41;
    run(1, 0, 32'h0042_0042, 1, 0);
    tests++;
    if (vd.size() != 1 || vd[0] !== 8'h41 || last_t != 1) begin
      fails++; $display("FAIL wos_byte: got n=%0d d=%h last_t=%0d want 1 41 1",
                        vd.size(), (vd.size() > 0) ? vd[0] : 8'h00, last_t);
    end
    tests++;
    if (done_t < 0 || r_pass !== 1'b1) begin
      fails++; $display("FAIL wos_pass: got done_t=%0d pass=%b want pass=1", done_t, r_pass);
    end
  endtask

  initial begin
    test_reset();
    test_hello_b2b();
    test_gap();
    test_bad_expected();
    test_timeout();
    test_empty();
    test_reset_midrun();
    test_write_on_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
